spart_bus_sched: RTL and testbench
==================================

# spart_bus_sched

Bus controller for the SPART register port. It programs the baud divisor from `br_cfg` after reset, and again whenever `br_cfg` changes. It then runs an echo loop, arbitrating the single shared `databus` between receive-buffer reads and transmit-buffer writes. Received bytes pass through a small internal FIFO so reception continues while the transmitter is busy. It sits between the board switches and the SPART instance, in place of the simple test driver.

## Interface
- `DEPTH`, 4: echo FIFO entries; power of two, at least 2.
- `DIV0`, 16'd650: divisor for `br_cfg`=0 (4800 baud at 50 MHz).
- `DIV1`, 16'd324: divisor for `br_cfg`=1 (9600 baud).
- `DIV2`, 16'd161: divisor for `br_cfg`=2 (19200 baud).
- `DIV3`, 16'd80: divisor for `br_cfg`=3 (38400 baud).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `br_cfg`  in  2  baud select from switches; asynchronous, synchronized internally.
- `rda`  in  1  SPART receive data available.
- `tbr`  in  1  SPART transmit buffer ready.
- `iocs`  out  1  chip select; high only in a bus-transaction cycle.
- `iorw`  out  1  1 = read, 0 = write.
- `ioaddr`  out  2  00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high.
- `databus`  inout  8  driven only when `iocs & ~iorw`, otherwise high-Z.
- `cfg_done`  out  1  divisor programmed; echo loop active.
- `fifo_cnt`  out  $clog2(DEPTH)+1  bytes held.

## Operation
- States:
  - SYNC (2 cycles, counter-timed).
  - CFG_LO: writes DB low, `ioaddr`=10, `databus`=DIVn[7:0].
  - CFG_HI: writes DB high, `ioaddr`=11, `databus`=DIVn[15:8].
  - RUN.
- Sequence is SYNC → CFG_LO → CFG_HI → RUN; each CFG state lasts exactly 1 cycle.
- `br_cfg` passes through a 2-flop synchronizer. The synchronized value is latched as `cfg_q` on entering CFG_LO. DIVn is selected by `cfg_q`.
- In RUN, each cycle:
  - Read is eligible when `rda` & `fifo_cnt`<DEPTH & no read holdoff.
  - Write is eligible when `tbr` & `fifo_cnt`>0 & no write holdoff.
- Arbitration: at most one transaction per cycle. When both are eligible, round-robin: grant the type not granted last. The `last_grant` flop resets to "write", so read wins the first tie.
- Read cycle: `iocs`=1, `iorw`=1, `ioaddr`=00. `databus` is sampled at the closing edge and pushed to the FIFO tail.
- Write cycle: `iocs`=1, `iorw`=0, `ioaddr`=00. `databus` carries the FIFO head, which is popped at the closing edge.
- Holdoff: the cycle after a read, no read is eligible (covers `rda` fall latency). The cycle after a write, no write is eligible.
- Idle RUN cycle: `iocs`=0, `iorw`=1, `ioaddr`=01, `databus` high-Z.
- Reconfiguration: in RUN, if the synchronized `br_cfg` != `cfg_q`:
  - that cycle is idle (no grant);
  - next state is CFG_LO and `cfg_done` drops;
  - FIFO contents are preserved and echo resumes after CFG_HI.
- FIFO: circular buffer, pointers wrap modulo DEPTH. Push and pop never occur in the same cycle.
  - Full: reads are blocked, so `rda` stays high in the SPART and no byte is lost.
  - Empty: writes are blocked.

## Timing
- Reset values:
  - state SYNC, `iocs`=0, `iorw`=1, `ioaddr`=01, `databus` high-Z;
  - `cfg_done`=0, `fifo_cnt`=0, pointers 0, holdoffs 0.
- Reset mid-operation: all of the above apply asynchronously. `databus` is released immediately and FIFO contents are discarded.
- After `rst_n` rises, cycles are numbered from the first clock edge:
  - cycles 0–1: SYNC;
  - cycle 2: CFG_LO;
  - cycle 3: CFG_HI;
  - cycle 4: first RUN, `cfg_done`=1.
- Bus outputs are combinational from the registered state, FIFO status and `rda`/`tbr`. All state, FIFO and counter updates occur on the rising edge closing the cycle.
- Echo latency: a read in cycle N allows a write of that byte in cycle N+1 if `tbr`=1.
- `br_cfg` change to reprogram: 2 synchronizer cycles + 1 idle cycle + CFG_LO + CFG_HI.

## Test plan
- Reset, `br_cfg`=1 → bus writes 8'h44 at `ioaddr` 10 in cycle 2, then 8'h01 at 11 in cycle 3; `cfg_done`=1 in cycle 4.
- RUN, `rda` pulse carrying 8'hA5, `tbr`=1 → read in cycle N, write of 8'hA5 at `ioaddr` 00 in cycle N+1; `fifo_cnt` goes 0→1→0.
- `tbr`=0, five receive bytes 01..05 offered → first four read, `fifo_cnt`=4, fifth held (`rda` stays high, no read). Raise `tbr` → writes 01,02,03,04, then 05 is read and echoed in order.
- `rda` and `tbr` continuously high with FIFO non-empty → reads and writes alternate every cycle; never two reads or two writes back-to-back.
- `br_cfg` 1→3 in RUN with 2 bytes buffered → `cfg_done` falls, DB writes 8'h50 then 8'h00, then the 2 bytes are echoed.
- Assert `rst_n` low during a write cycle → `databus` goes high-Z and `iocs`=0 immediately; `fifo_cnt`=0.

Source files
------------

// File: rtl/spart_bus_if.sv
// SPART register-port bus bundle.
// Groups the chip-select/read-write/address strobes, the shared bidirectional
// data bus and the two SPART status lines (rda, tbr).
//   master : the bus controller (drives iocs/iorw/ioaddr, samples rda/tbr)
//   slave  : the SPART side (samples the strobes, drives rda/tbr)
// databus is a resolved net; each side drives it only in its own cycle type
// and releases it to high-Z otherwise.
interface spart_bus_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs,
        output iorw,
        output ioaddr,
        inout  databus,
        input  rda,
        input  tbr
    );

    modport slave (
        input  iocs,
        input  iorw,
        input  ioaddr,
        inout  databus,
        output rda,
        output tbr
    );
endinterface

// File: rtl/spart_bus_sched.sv
// SPART bus controller: programs the baud divisor selected by br_cfg, then
// runs an echo loop that reads received bytes into a small FIFO and writes
// them back to the transmit buffer, one bus transaction per cycle at most.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   br_cfg      baud select from switches (asynchronous, synchronized here)
//   bus         SPART register port (master side): iocs, iorw, ioaddr,
//               databus, rda, tbr
//   cfg_done    divisor programmed, echo loop active
//   fifo_cnt    bytes currently held in the echo FIFO
//
// state  | meaning
// SYNC   | 2 counter-timed cycles after reset while br_cfg settles
// CFG_LO | write divisor low byte (ioaddr 10)
// CFG_HI | write divisor high byte (ioaddr 11)
// RUN    | echo loop; leaves for CFG_LO when br_cfg changes
module spart_bus_sched #(
    parameter int          DEPTH = 4,
    parameter logic [15:0] DIV0  = 16'd650,
    parameter logic [15:0] DIV1  = 16'd324,
    parameter logic [15:0] DIV2  = 16'd161,
    parameter logic [15:0] DIV3  = 16'd80
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 br_cfg,
    spart_bus_if.master                bus,
    output logic                       cfg_done,
    output logic [$clog2(DEPTH):0]     fifo_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {SYNC, CFG_LO, CFG_HI, RUN} state_t;

    state_t        state, state_nxt;
    logic          sync_cnt;
    logic [1:0]    cfg_s1, cfg_s2, cfg_q;
    logic          latch_cfg;
    logic [15:0]   div_sel;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          rd_hold, wr_hold, last_rd;
    logic          rd_ok, wr_ok, do_rd, do_wr;

    logic          iocs, iorw, drive;
    logic [1:0]    ioaddr;
    logic [7:0]    dout;

    always_comb begin
        div_sel = DIV0;
        case (cfg_q)
            2'd0: div_sel = DIV0;
            2'd1: div_sel = DIV1;
            2'd2: div_sel = DIV2;
            2'd3: div_sel = DIV3;
            default: div_sel = DIV0;
        endcase
    end

    assign rd_ok = bus.rda & (cnt < FULL_CNT) & ~rd_hold;
    assign wr_ok = bus.tbr & (cnt != '0) & ~wr_hold;

    always_comb begin
        state_nxt = state;
        latch_cfg = 1'b0;
        do_rd     = 1'b0;
        do_wr     = 1'b0;
        iocs      = 1'b0;
        iorw      = 1'b1;
        ioaddr    = 2'b01;
        dout      = 8'h00;
        case (state)
            SYNC: begin
                if (sync_cnt == 1'b0) begin
                    state_nxt = CFG_LO;
                    latch_cfg = 1'b1;
                end
            end
            CFG_LO: begin
                iocs      = 1'b1;
                iorw      = 1'b0;
                ioaddr    = 2'b10;
                dout      = div_sel[7:0];
                state_nxt = CFG_HI;
            end
            CFG_HI: begin
                iocs      = 1'b1;
                iorw      = 1'b0;
                ioaddr    = 2'b11;
                dout      = div_sel[15:8];
                state_nxt = RUN;
            end
            RUN: begin
                if (cfg_s2 != cfg_q) begin
                    // Switch change: idle this cycle, reprogram, keep the FIFO.
                    state_nxt = CFG_LO;
                    latch_cfg = 1'b1;
                end else begin
                    // Round-robin on a tie: last_rd=0 means write went last.
                    if (rd_ok && wr_ok) begin
                        do_rd = ~last_rd;
                        do_wr = last_rd;
                    end else begin
                        do_rd = rd_ok;
                        do_wr = wr_ok;
                    end
                    if (do_rd) begin
                        iocs   = 1'b1;
                        iorw   = 1'b1;
                        ioaddr = 2'b00;
                    end else if (do_wr) begin
                        iocs   = 1'b1;
                        iorw   = 1'b0;
                        ioaddr = 2'b00;
                        dout   = mem[rd_ptr];
                    end
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    assign drive       = iocs & ~iorw;
    assign bus.iocs    = iocs;
    assign bus.iorw    = iorw;
    assign bus.ioaddr  = ioaddr;
    assign bus.databus = drive ? dout : {8{1'bz}};
    assign cfg_done    = (state == RUN);
    assign fifo_cnt    = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC;
            sync_cnt <= 1'b1;
            cfg_s1   <= 2'd0;
            cfg_s2   <= 2'd0;
            cfg_q    <= 2'd0;
        end else begin
            state  <= state_nxt;
            cfg_s1 <= br_cfg;
            cfg_s2 <= cfg_s1;
            if (state == SYNC && sync_cnt != 1'b0) begin
                sync_cnt <= sync_cnt - 1'b1;
            end
            // cfg_s1 is what cfg_s2 holds after this same edge, so cfg_q
            // matches the synchronized value from the first CFG_LO cycle on.
            if (latch_cfg) begin
                cfg_q <= cfg_s1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_hold <= 1'b0;
            wr_hold <= 1'b0;
            last_rd <= 1'b0;
        end else begin
            rd_hold <= do_rd;
            wr_hold <= do_wr;
            if (do_rd) begin
                wr_ptr  <= wr_ptr + 1'b1;
                cnt     <= cnt + 1'b1;
                last_rd <= 1'b1;
            end else if (do_wr) begin
                rd_ptr  <= rd_ptr + 1'b1;
                cnt     <= cnt - 1'b1;
                last_rd <= 1'b0;
            end
        end
    end

    // Storage needs no reset: the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_rd) begin
            mem[wr_ptr] <= bus.databus;
        end
    end
endmodule

// File: tb/tb_spart_bus_sched.sv
// Bench for spart_bus_sched: a SPART model feeds random receive bytes and
// transmit-ready, a scoreboard holds expected divisor writes and echoed bytes,
// and a negedge monitor checks every bus cycle against the arbitration rules.
module tb_spart_bus_sched;
    localparam int DEPTH = 4;
    localparam int RD = 1, WR = 2, IDLE = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] br_cfg = 2'd1;
    logic       cfg_done;
    logic [2:0] fifo_cnt;
    logic [7:0] rx_data = 8'h00;

    spart_bus_if bif ();

    spart_bus_sched #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .br_cfg   (br_cfg),
        .bus      (bif.master),
        .cfg_done (cfg_done),
        .fifo_cnt (fifo_cnt)
    );

    // SPART side drives the bus only during a read cycle.
    assign bif.databus = (bif.iocs && bif.iorw) ? rx_data : 8'hzz;

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_echo[$];
    logic [9:0]  exp_cfg[$];
    bit          rda_en = 1'b0;
    bit          tbr_en = 1'b0;

    function automatic void check_eq(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, req, req, $time);
    endfunction

    function automatic logic [15:0] div_of(input logic [1:0] c);
        case (c)
            2'd0: return 16'd650;
            2'd1: return 16'd324;
            2'd2: return 16'd161;
            default: return 16'd80;
        endcase
    endfunction

    function automatic void expect_cfg(input logic [1:0] c);
        logic [15:0] d;
        d = div_of(c);
        exp_cfg.push_back({2'b10, d[7:0]});
        exp_cfg.push_back({2'b11, d[15:8]});
    endfunction

    function automatic void drive_spart();
        bif.rda = rda_en && (rx_q.size() > 0);
        rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        bif.tbr = tbr_en;
    endfunction

    function automatic void offer(input logic [7:0] b);
        rx_q.push_back(b);
        exp_echo.push_back(b);
        drive_spart();
    endfunction

    task automatic tick();
        bit did_rd;
        @(negedge clk);
        did_rd = rst_n && bif.iocs && bif.iorw;
        @(posedge clk);
        #1;
        if (did_rd && rx_q.size() > 0) void'(rx_q.pop_front());
        drive_spart();
    endtask

    // Monitor: reference model of counts, holdoffs and round-robin.
    int         m_cnt = 0;
    bit         m_prev_rd = 0, m_prev_wr = 0, m_last_rd = 0;
    int         m_stable = 0;
    logic [1:0] m_prev_cfg = 2'd0;

    always @(negedge clk) begin
        bit is_rd, is_wr, is_cfg, rd_e, wr_e;
        int want, got;
        logic [9:0] e;
        if (br_cfg != m_prev_cfg) m_stable = 0;
        else if (m_stable < 1000) m_stable++;
        m_prev_cfg = br_cfg;
        if (!rst_n) begin
            m_cnt = 0; m_prev_rd = 0; m_prev_wr = 0; m_last_rd = 0;
        end else begin
            is_rd  = bif.iocs && bif.iorw;
            is_wr  = bif.iocs && !bif.iorw && bif.ioaddr == 2'b00;
            is_cfg = bif.iocs && !bif.iorw && bif.ioaddr[1];
            if (!bif.iocs) check_eq("idle_bus", {bif.iorw, bif.ioaddr}, 3'b101);
            check_eq("fifo_cnt", fifo_cnt, m_cnt);
            if (is_rd) check_eq("rd_addr", bif.ioaddr, 0);
            if (is_cfg) begin
                if (exp_cfg.size() == 0) check_eq("cfg_unexpected", {bif.ioaddr, bif.databus}, 0);
                else begin
                    e = exp_cfg.pop_front();
                    check_eq("cfg_write", {bif.ioaddr, bif.databus}, e);
                end
            end
            if (cfg_done && m_stable >= 3) begin
                rd_e = bif.rda && m_cnt < DEPTH && !m_prev_rd;
                wr_e = bif.tbr && m_cnt > 0 && !m_prev_wr;
                if (rd_e && wr_e) want = m_last_rd ? WR : RD;
                else if (rd_e)    want = RD;
                else if (wr_e)    want = WR;
                else              want = IDLE;
                got = is_rd ? RD : (is_wr ? WR : IDLE);
                check_eq("grant", got, want);
            end
            if (is_wr) begin
                if (exp_echo.size() == 0) check_eq("echo_unexpected", bif.databus, 0);
                else check_eq("echo_byte", bif.databus, exp_echo.pop_front());
            end
            if (is_rd) m_cnt++;
            if (is_wr) m_cnt--;
            m_prev_rd = is_rd;
            m_prev_wr = is_wr;
            if (is_rd || is_wr) m_last_rd = is_rd;
        end
    end

    initial begin
        bit seen;
        bif.rda = 1'b0;
        bif.tbr = 1'b0;
        #21;
        check_eq("rst_iocs", bif.iocs, 0);
        check_eq("rst_iorw", bif.iorw, 1);
        check_eq("rst_ioaddr", bif.ioaddr, 1);
        check_eq("rst_cfg_done", cfg_done, 0);
        check_eq("rst_fifo_cnt", fifo_cnt, 0);

        // Startup programming sequence with br_cfg=1.
        @(posedge clk); #1;
        expect_cfg(2'd1);
        rst_n = 1'b1;
        tick();
        check_eq("c1_sync_iocs", bif.iocs, 0);
        tick();
        check_eq("c2_lo", {bif.iocs, bif.iorw, bif.ioaddr, bif.databus}, {1'b1, 1'b0, 2'b10, 8'h44});
        tick();
        check_eq("c3_hi", {bif.iocs, bif.iorw, bif.ioaddr, bif.databus}, {1'b1, 1'b0, 2'b11, 8'h01});
        check_eq("c3_cfg_done", cfg_done, 0);
        tick();
        check_eq("c4_cfg_done", cfg_done, 1);

        // Single byte echo.
        rda_en = 1; tbr_en = 1;
        offer(8'hA5);
        repeat (6) tick();
        check_eq("a5_drained", exp_echo.size(), 0);

        // Fill to full with transmitter busy.
        tbr_en = 0; drive_spart();
        for (int i = 1; i <= 5; i++) offer(8'(i));
        repeat (12) tick();
        check_eq("full_cnt", fifo_cnt, 4);
        check_eq("full_rda_held", bif.rda, 1);
        check_eq("full_rx_left", rx_q.size(), 1);
        tbr_en = 1; drive_spart();
        repeat (20) tick();
        check_eq("full_drained", exp_echo.size(), 0);

        // Continuous rda/tbr: alternation is enforced by the grant model.
        for (int i = 0; i < 20; i++) offer(8'($urandom_range(0, 255)));
        repeat (60) tick();
        check_eq("stream_drained", exp_echo.size(), 0);

        // Reconfigure 1 -> 3 with two bytes buffered.
        tbr_en = 0; drive_spart();
        offer(8'h3C); offer(8'hC3);
        repeat (8) tick();
        check_eq("recfg_buf", fifo_cnt, 2);
        br_cfg = 2'd3;
        expect_cfg(2'd3);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin tick(); if (!cfg_done) seen = 1; end
        check_eq("recfg_drop", seen, 1);
        check_eq("recfg_keep", fifo_cnt, 2);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin tick(); if (cfg_done) seen = 1; end
        check_eq("recfg_back", seen, 1);
        tbr_en = 1; drive_spart();
        repeat (10) tick();
        check_eq("recfg_drained", exp_echo.size(), 0);
        check_eq("recfg_cfg_done", exp_cfg.size(), 0);

        // Random traffic with occasional baud changes.
        for (int c = 0; c < 400; c++) begin
            rda_en = ($urandom_range(0, 3) != 0);
            tbr_en = ($urandom_range(0, 2) != 0);
            if (rx_q.size() < 3 && $urandom_range(0, 3) == 0) offer(8'($urandom_range(0, 255)));
            if (c % 100 == 50) begin
                logic [1:0] nc;
                nc = br_cfg + 2'(1 + $urandom_range(0, 2));
                br_cfg = nc;
                expect_cfg(nc);
            end
            drive_spart();
            tick();
        end
        rda_en = 1; tbr_en = 1; drive_spart();
        repeat (60) tick();
        check_eq("rand_drained", exp_echo.size(), 0);
        check_eq("rand_cfg_drained", exp_cfg.size(), 0);

        // Reset in the middle of a write cycle.
        tbr_en = 0; drive_spart();
        offer(8'h11); offer(8'h22); offer(8'h33);
        repeat (10) tick();
        tbr_en = 1; drive_spart();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bif.iocs && !bif.iorw && bif.ioaddr == 2'b00) seen = 1;
        end
        check_eq("mid_write_found", seen, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_drive", bif.iocs && !bif.iorw, 0);
        check_eq("mid_rst_iocs", bif.iocs, 0);
        check_eq("mid_rst_cnt", fifo_cnt, 0);
        check_eq("mid_rst_cfg_done", cfg_done, 0);
        rx_q.delete(); exp_echo.delete(); exp_cfg.delete();
        drive_spart();
        @(posedge clk); #1;
        expect_cfg(br_cfg);
        rst_n = 1'b1;
        repeat (6) tick();
        check_eq("post_rst_cfg", cfg_done, 1);
        offer(8'h5A);
        repeat (6) tick();
        check_eq("post_rst_echo", exp_echo.size(), 0);
        check_eq("post_rst_cfg_q", exp_cfg.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
